// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with oversampled mid-bit sampling and a one-entry valid/ready holding register
module uart_rx_core #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       busy_o,
    output logic       frame_err_o,
    output logic       overrun_o
);
    localparam int RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV = RAW < 1 ? 1 : RAW;
    localparam int CW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t        state, state_nxt;
    logic [1:0]    sync;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [SW-1:0] sc;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          tick, half, full, stop_smp, done;

    assign rx_s     = sync[1];
    assign tick     = cnt == CW'(DIV - 1);
    assign half     = tick && sc == SW'(OVERSAMPLE / 2 - 1);
    assign full     = tick && sc == SW'(OVERSAMPLE - 1);
    assign stop_smp = state == STOP && full;
    assign done     = stop_smp && rx_s;

    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = rx_s ? IDLE : START;
            START:   state_nxt = half ? (rx_s ? IDLE : DATA) : START;
            DATA:    state_nxt = (full && bit_idx == 3'd7) ? STOP : DATA;
            STOP:    state_nxt = full ? (rx_s ? IDLE : BRK) : STOP;
            BRK:     state_nxt = rx_s ? IDLE : BRK;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o = state != IDLE;
    end

    // Divider and tick count are held at zero in IDLE so sampling phase is anchored to the start edge
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sync    <= 2'b11;
            cnt     <= '0;
            sc      <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            sync    <= {sync[0], rx_i};
            cnt     <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
            sc      <= (state == IDLE || (state == START && half) || full) ? '0 : tick ? sc + 1'b1 : sc;
            bit_idx <= state != DATA ? '0 : full ? bit_idx + 1'b1 : bit_idx;
            if (state == DATA && full) shift <= {rx_s, shift[7:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= stop_smp && !rx_s;
            overrun_o   <= done && valid_o && !ready_i;
            if (done && (!valid_o || ready_i)) begin
                data_o  <= shift;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed and randomized frames checked against expected bytes, timing and status pulses
module tb_uart_rx_core;
    localparam int BIT = 32;

    logic       clk = 1'b0, rst_i = 1'b0, rx_i = 1'b1, ready_i = 1'b1;
    logic [7:0] data_o;
    logic       valid_o, busy_o, frame_err_o, overrun_o;

    int cyc = 0, errors = 0, checks = 0, t_fall = 0;
    int n_rx = 0, n_ferr = 0, n_ovr = 0, n_both = 0, n_busy = 0, rise_cyc = 0, width = 0;
    logic       v_q = 1'b0;
    logic [7:0] rx_log [256];

    uart_rx_core #(.CLK_HZ(3200000), .BAUD(100000), .OVERSAMPLE(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .rx_i(rx_i), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .busy_o(busy_o), .frame_err_o(frame_err_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        v_q <= valid_o;
        if (valid_o && !v_q) rise_cyc <= cyc;
        if (!valid_o && v_q) width <= cyc - rise_cyc;
        if (valid_o && ready_i) begin
            rx_log[n_rx[7:0]] <= data_o;
            n_rx <= n_rx + 1;
        end
        if (frame_err_o) n_ferr <= n_ferr + 1;
        if (overrun_o) n_ovr <= n_ovr + 1;
        if (frame_err_o && overrun_o) n_both <= n_both + 1;
        if (busy_o) n_busy <= n_busy + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopb);
        rx_i = 1'b0;
        t_fall = cyc;
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            wait_clks(BIT);
        end
        rx_i = stopb;
        wait_clks(BIT);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0, k0, f0, o0, d;
        logic idle;
        logic [7:0] exp_q [24];

        wait_clks(3);
        @(negedge clk);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_data", 32'(data_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_ferr", 32'(frame_err_o), 0);
        chk("rst_ovr", 32'(overrun_o), 0);
        @(posedge clk);
        #1 rst_i = 1'b1;
        wait_clks(5);

        b0 = n_rx; k0 = n_busy;
        send_frame(8'hA5, 1'b1);
        wait_clks(4);
        chk("a5_count", n_rx - b0, 1);
        chk("a5_data", 32'(rx_log[8'(b0)]), 32'hA5);
        chk("a5_latency", rise_cyc - t_fall, 307);
        chk("a5_width", width, 1);
        chk("a5_busy_cycles", n_busy - k0, 304);

        b0 = n_rx; f0 = n_ferr; o0 = n_ovr;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h00, 1'b1);
        wait_clks(4);
        chk("b2b_count", n_rx - b0, 3);
        chk("b2b_d0", 32'(rx_log[8'(b0)]), 32'h3C);
        chk("b2b_d1", 32'(rx_log[8'(b0 + 1)]), 32'hFF);
        chk("b2b_d2", 32'(rx_log[8'(b0 + 2)]), 32'h00);
        chk("b2b_ferr", n_ferr - f0, 0);
        chk("b2b_ovr", n_ovr - o0, 0);

        b0 = n_rx; f0 = n_ferr; k0 = n_busy;
        rx_i = 1'b0;
        t_fall = cyc;
        wait_clks(10);
        rx_i = 1'b1;
        idle = 1'b0;
        d = -1;
        for (int i = 0; i < 40 && !idle; i++) begin
            @(negedge clk);
            if (!busy_o) begin
                idle = 1'b1;
                d = cyc - t_fall;
            end
        end
        chk("glitch_idle_in_time", 32'(idle && d <= 19), 1);
        chk("glitch_busy_cycles", n_busy - k0, 16);
        @(posedge clk);
        #1;
        wait_clks(40);
        chk("glitch_no_valid", n_rx - b0, 0);
        chk("glitch_no_ferr", n_ferr - f0, 0);

        b0 = n_rx; f0 = n_ferr;
        send_frame(8'h55, 1'b0);
        wait_clks(100);
        @(negedge clk);
        chk("brk_busy_held", 32'(busy_o), 1);
        @(posedge clk);
        #1 rx_i = 1'b1;
        wait_clks(6);
        @(negedge clk);
        chk("brk_busy_release", 32'(busy_o), 0);
        chk("brk_ferr_once", n_ferr - f0, 1);
        chk("brk_no_valid", n_rx - b0, 0);
        @(posedge clk);
        #1;
        send_frame(8'h12, 1'b1);
        wait_clks(4);
        chk("brk_next_count", n_rx - b0, 1);
        chk("brk_next_data", 32'(rx_log[8'(b0)]), 32'h12);
        chk("brk_ferr_after", n_ferr - f0, 1);

        ready_i = 1'b0;
        b0 = n_rx; o0 = n_ovr; f0 = n_ferr;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_clks(4);
        @(negedge clk);
        chk("ovr_valid_held", 32'(valid_o), 1);
        chk("ovr_data_held", 32'(data_o), 32'h11);
        chk("ovr_pulse_once", n_ovr - o0, 1);
        chk("ovr_no_ferr", n_ferr - f0, 0);
        @(posedge clk);
        #1 ready_i = 1'b1;
        @(posedge clk);
        #1 ready_i = 1'b0;
        @(negedge clk);
        chk("ovr_valid_drop", 32'(valid_o), 0);
        chk("ovr_data_keep", 32'(data_o), 32'h11);
        chk("ovr_accept_count", n_rx - b0, 1);
        chk("ovr_accept_data", 32'(rx_log[8'(b0)]), 32'h11);

        ready_i = 1'b1;
        @(posedge clk);
        #1;
        b0 = n_rx;
        rx_i = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 4; i++) begin
            rx_i = (8'h99 >> i) & 1'b1;
            wait_clks(BIT);
        end
        rx_i = 1'b1;
        wait_clks(10);
        rst_i = 1'b0;
        wait_clks(1);
        rst_i = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(valid_o), 0);
        chk("mid_rst_busy", 32'(busy_o), 0);
        chk("mid_rst_data", 32'(data_o), 0);
        chk("mid_rst_status", 32'({frame_err_o, overrun_o}), 0);
        @(posedge clk);
        #1;
        wait_clks(400);
        chk("mid_rst_no_valid", n_rx - b0, 0);
        send_frame(8'h42, 1'b1);
        wait_clks(4);
        chk("mid_rst_next_count", n_rx - b0, 1);
        chk("mid_rst_next_data", 32'(rx_log[8'(b0)]), 32'h42);

        b0 = n_rx; f0 = n_ferr; o0 = n_ovr;
        for (int i = 0; i < 24; i++) begin
            exp_q[i] = 8'($urandom);
            send_frame(exp_q[i], 1'b1);
            d = $urandom_range(0, 40);
            if (d > 0) wait_clks(d);
        end
        wait_clks(4);
        chk("rnd_count", n_rx - b0, 24);
        for (int i = 0; i < 24; i++) chk($sformatf("rnd_data%0d", i), 32'(rx_log[8'(b0 + i)]), 32'(exp_q[i]));
        chk("rnd_no_ferr", n_ferr - f0, 0);
        chk("rnd_no_ovr", n_ovr - o0, 0);
        chk("never_both_pulses", n_both, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
UART receive front end. It deserializes the asynchronous serial line driven by the SoC uart interface's tx_o (tb loopback rx_i = tx_o) into bytes for the peripheral's RX register/bus side. The frame format is fixed 8N1, LSB first, with oversampled mid-bit sampling. Received bytes are delivered through a valid/ready handshake backed by a one-entry holding register, with framing and overrun status pulses.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, line baud rate
OVERSAMPLE, 16, sample ticks per bit (even, >=4)

Ports:
clk_i  input  1  system clock, rising edge
rst_i  input  1  reset, synchronous, active-low (0 = reset)
rx_i  input  1  asynchronous serial line, idle high
data_o  output  8  received byte, valid when valid_o=1
valid_o  output  1  byte available
ready_i  input  1  consumer accepts byte when valid_o&ready_i
busy_o  output  1  frame reception in progress (state != IDLE)
frame_err_o  output  1  1-cycle pulse: stop bit sampled low
overrun_o  output  1  1-cycle pulse: completed byte dropped, holding register full

Behaviour:
- Tick divider: DIV = max(1, CLK_HZ/(BAUD*OVERSAMPLE)), integer floor. The counter runs 0..DIV-1 and tick = (cnt == DIV-1). In IDLE the counter is held at 0, so it is aligned to start-edge detection.
- Synchronizer: 2 flops on rx_i, reset value 1. All FSM decisions use the synchronized rx_s only.
- Reset (rst_i=0 at a clk edge): state=IDLE, data_o=0, valid_o=0, busy_o=0, frame_err_o=0, overrun_o=0, sync flops=1, counters=0. Reset mid-frame abandons the frame, and no valid_o is produced for it.
- FSM states:
  - IDLE: if rx_s==0, go to START with tick count 0.
  - START: count ticks. On tick number OVERSAMPLE/2 (mid start bit): if rx_s==0, go to DATA with bit index 0 and tick count 0. Otherwise go to IDLE (glitch rejected, no outputs).
  - DATA: every OVERSAMPLE ticks, sample rx_s into shift[7] and shift right (LSB first). After the 8th sample, go to STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - If 1: byte complete, go to IDLE.
    - If 0: pulse frame_err_o, discard the byte, go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. This prevents a held-low line from re-triggering starts.
- Output register:
  - On byte complete with valid_o==0, or with valid_o&ready_i in that same cycle: data_o <= shift and valid_o <= 1 on the next edge. Latency is 1 clk after the stop-sample tick.
  - On byte complete with valid_o==1 and ready_i==0: the new byte is dropped, overrun_o pulses 1 cycle, and data_o/valid_o are unchanged.
  - valid_o&ready_i with no completion: valid_o <= 0 next edge. data_o holds its last value.
  - data_o must not change while valid_o=1 and ready_i=0.
- Frame timing (bit = OVERSAMPLE*DIV clocks, measured from start detection): mid-start check at bit/2, data bit n sampled at bit/2 + (n+1)*bit, stop at bit/2 + 9*bit.
- frame_err_o and overrun_o are never asserted together. Each is high for exactly one cycle per event.
- Back-to-back frames: a start bit immediately following a valid stop sample (mid-stop, half a bit early) is detected correctly.

Test Plan:
- Params CLK_HZ=3200000, BAUD=100000, OVERSAMPLE=16 (DIV=2, bit=32 clk). Send 0xA5 with ready_i=1 -> valid_o rises 304 (+2 sync, +1 reg) clk after rx_i falls, data_o=0xA5, valid_o high 1 cycle, busy_o high during frame.
- Send 0x3C, 0xFF, 0x00 back-to-back with 1 stop bit each, ready_i=1 -> three valid_o pulses with data_o=0x3C,0xFF,0x00 in order, no error pulses.
- rx_i low glitch of 10 clk in IDLE -> no valid_o, busy_o returns 0 within bit/2+3 clk, no frame_err_o.
- Send 0x55 with stop bit driven 0, line held low 100 clk then high -> frame_err_o one pulse, no valid_o, busy_o stays 1 until line high, then the next frame 0x12 is received correctly.
- ready_i=0; send 0x11 then 0x22 -> data_o=0x11 held, overrun_o pulses once at the 0x22 stop sample. Then ready_i=1 for 1 cycle -> valid_o drops.
- Assert rst_i=0 for 1 cycle during data bit 4 of 0x99 -> all outputs 0 next cycle, no valid_o for 0x99, and a subsequent 0x42 is received correctly.
